// File: rtl/gmii_tx_framer_if.sv
// rtl/gmii_tx_framer_if.sv - payload byte stream feeding the GMII TX framer
interface gmii_tx_framer_if;
   logic       in_valid_i;
   logic       in_last_i;
   logic [7:0] in_data_i;
   logic       in_ready_o;

   modport master (output in_valid_i, output in_last_i, output in_data_i, input in_ready_o);
   modport slave  (input in_valid_i, input in_last_i, input in_data_i, output in_ready_o);
endinterface

// File: rtl/gmii_tx_framer.sv
// rtl/gmii_tx_framer.sv - GMII TX framer: preamble, SFD, payload, optional pad, CRC-32 FCS, IFG
// Zero padding up to MIN_FRAME is compiled in only when GMII_TX_PAD_EN is defined.
module gmii_tx_framer #(
   parameter int PREAMBLE_LEN = 7,
   parameter int MIN_IFG      = 12,
   parameter int MIN_FRAME    = 60
) (
   input  logic             clk,
   input  logic             rst,
   gmii_tx_framer_if.slave  s,
   output logic             gmii_en_o,
   output logic             gmii_er_o,
   output logic [7:0]       gmii_data_o
);

   typedef enum logic [2:0] {
      IDLE, PRE, SFD, DATA, FCS, IFG
`ifdef GMII_TX_PAD_EN
      , PAD
`endif
   } state_t;

   localparam logic [7:0] PRE_LAST    = 8'(PREAMBLE_LEN);
   localparam logic [7:0] IFG_LAST    = 8'(MIN_IFG);
   localparam state_t     START_STATE = (PREAMBLE_LEN > 1) ? PRE : SFD;

   if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 255 || MIN_IFG < 0 || MIN_IFG > 255 ||
       MIN_FRAME < 1 || MIN_FRAME > 2047) begin : g_bad_params
      $error("gmii_tx_framer: parameter out of range");
   end

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   state_t      state_q, state_d;
   logic [7:0]  aux_q, aux_d;
   logic [31:0] crc_q, crc_d;
   logic        drain_q, drain_d;
   logic        in_ready_q, in_ready_d;
   logic        en_q, en_d;
   logic        er_q, er_d;
   logic [7:0]  data_q, data_d;

`ifdef GMII_TX_PAD_EN
   localparam logic [10:0] MIN_CNT = 11'(MIN_FRAME);
   logic [10:0] byte_cnt_q, byte_cnt_d;
   logic [10:0] byte_cnt_inc;
   logic        below_min;

   assign byte_cnt_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
   assign below_min    = byte_cnt_inc < MIN_CNT;
`endif

   // aux_q counts preamble bytes, FCS byte index, or IFG cycles depending on state
   always_comb begin
      state_d  = state_q;
      aux_d    = aux_q;
      crc_d    = crc_q;
      drain_d  = drain_q;
      en_d     = 1'b0;
      er_d     = 1'b0;
      data_d   = 8'h00;
`ifdef GMII_TX_PAD_EN
      byte_cnt_d = byte_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (s.in_valid_i) begin
               state_d = START_STATE;
               aux_d   = 8'd1;
               en_d    = 1'b1;
               data_d  = 8'h55;
            end
         end
         PRE: begin
            en_d   = 1'b1;
            data_d = 8'h55;
            aux_d  = aux_q + 8'd1;
            if (aux_q + 8'd1 == PRE_LAST) state_d = SFD;
         end
         SFD: begin
            en_d    = 1'b1;
            data_d  = 8'hD5;
            state_d = DATA;
            crc_d   = 32'hFFFFFFFF;
`ifdef GMII_TX_PAD_EN
            byte_cnt_d = '0;
`endif
         end
         DATA: begin
            en_d = 1'b1;
            if (s.in_valid_i) begin
               data_d = s.in_data_i;
               crc_d  = crc_byte(crc_q, s.in_data_i);
`ifdef GMII_TX_PAD_EN
               byte_cnt_d = byte_cnt_inc;
`endif
               if (s.in_last_i) begin
                  aux_d = '0;
`ifdef GMII_TX_PAD_EN
                  state_d = below_min ? PAD : FCS;
`else
                  state_d = FCS;
`endif
               end
            end else begin
               // source underrun: poison the frame and swallow the rest of it
               er_d    = 1'b1;
               state_d = IFG;
               aux_d   = '0;
               drain_d = 1'b1;
            end
         end
`ifdef GMII_TX_PAD_EN
         PAD: begin
            en_d       = 1'b1;
            crc_d      = crc_byte(crc_q, 8'h00);
            byte_cnt_d = byte_cnt_inc;
            if (!below_min) begin
               state_d = FCS;
               aux_d   = '0;
            end
         end
`endif
         FCS: begin
            en_d = 1'b1;
            case (aux_q[1:0])
               2'd0:    data_d = ~crc_q[7:0];
               2'd1:    data_d = ~crc_q[15:8];
               2'd2:    data_d = ~crc_q[23:16];
               default: data_d = ~crc_q[31:24];
            endcase
            aux_d = aux_q + 8'd1;
            if (aux_q[1:0] == 2'd3) begin
               state_d = IFG;
               aux_d   = '0;
            end
         end
         IFG: begin
            if (drain_q && s.in_valid_i && s.in_last_i) drain_d = 1'b0;
            if (aux_q != IFG_LAST) begin
               aux_d = aux_q + 8'd1;
            end else if (!drain_q) begin
               if (s.in_valid_i) begin
                  state_d = START_STATE;
                  aux_d   = 8'd1;
                  en_d    = 1'b1;
                  data_d  = 8'h55;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == DATA) || ((state_d == IFG) && drain_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         aux_q      <= '0;
         crc_q      <= 32'hFFFFFFFF;
         drain_q    <= 1'b0;
         in_ready_q <= 1'b0;
         en_q       <= 1'b0;
         er_q       <= 1'b0;
         data_q     <= 8'h00;
`ifdef GMII_TX_PAD_EN
         byte_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         aux_q      <= aux_d;
         crc_q      <= crc_d;
         drain_q    <= drain_d;
         in_ready_q <= in_ready_d;
         en_q       <= en_d;
         er_q       <= er_d;
         data_q     <= data_d;
`ifdef GMII_TX_PAD_EN
         byte_cnt_q <= byte_cnt_d;
`endif
      end
   end

   assign s.in_ready_o  = in_ready_q;
   assign gmii_en_o     = en_q;
   assign gmii_er_o     = er_q;
   assign gmii_data_o   = data_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb/tb_gmii_tx_framer.sv - self-checking bench for gmii_tx_framer against a frame-level model
module tb_gmii_tx_framer;
   localparam int PL   = 7;
   localparam int IFG  = 12;
   localparam int MINF = 60;
`ifdef GMII_TX_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   typedef logic [7:0] bq_t[$];

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en, er;
   logic [7:0] d;
   int         n_checks = 0;
   int         n_fail   = 0;

   always #4 clk = ~clk;

   gmii_tx_framer_if intf();

   gmii_tx_framer dut (
      .clk         (clk),
      .rst         (rst),
      .s           (intf),
      .gmii_en_o   (en),
      .gmii_er_o   (er),
      .gmii_data_o (d)
   );

   logic       log_en[$];
   logic       log_er[$];
   logic [7:0] log_d[$];
   logic       log_rdy[$];
   int         run_st[$];
   int         run_ln[$];

   always @(negedge clk) begin
      log_en.push_back(en);
      log_er.push_back(er);
      log_d.push_back(d);
      log_rdy.push_back(intf.in_ready_o);
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [31:0] fcs_model(bq_t b);
      logic [31:0] c;
      logic        fb;
      c = 32'hFFFFFFFF;
      foreach (b[i]) begin
         for (int k = 0; k < 8; k++) begin
            fb = c[0] ^ b[i][k];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
         end
      end
      return ~c;
   endfunction

   function automatic bq_t model_frame(bq_t p, int under);
      bq_t         q;
      bq_t         body;
      logic [31:0] f;
      for (int i = 0; i < PL; i++) q.push_back(8'h55);
      q.push_back(8'hD5);
      if (under >= 0) begin
         for (int i = 0; i < under; i++) q.push_back(p[i]);
         q.push_back(8'h00);
         return q;
      end
      body = p;
      if (PAD_EN) while (body.size() < MINF) body.push_back(8'h00);
      f = fcs_model(body);
      foreach (body[i]) q.push_back(body[i]);
      for (int k = 0; k < 4; k++) q.push_back(f[8*k +: 8]);
      return q;
   endfunction

   function automatic bq_t rand_payload(int n);
      bq_t p;
      for (int i = 0; i < n; i++) p.push_back(8'($urandom));
      return p;
   endfunction

   function automatic int first_diff(int st, bq_t exp);
      for (int i = 0; i < exp.size(); i++) begin
         if (st + i >= log_d.size() || log_d[st+i] !== exp[i]) return i;
      end
      return -1;
   endfunction

   function automatic int er_count(int st, int ln);
      int c;
      c = 0;
      for (int i = st; i < st + ln && i < log_er.size(); i++) if (log_er[i] === 1'b1) c++;
      return c;
   endfunction

   function automatic int rdy_count();
      int c;
      c = 0;
      foreach (log_rdy[i]) if (log_rdy[i] === 1'b1) c++;
      return c;
   endfunction

   task automatic find_runs();
      int k;
      run_st.delete();
      run_ln.delete();
      for (int j = 0; j < log_en.size(); j++) begin
         if (log_en[j] === 1'b1 && (j == 0 || log_en[j-1] !== 1'b1)) begin
            k = j;
            while (k < log_en.size() && log_en[k] === 1'b1) k++;
            run_st.push_back(j);
            run_ln.push_back(k - j);
         end
      end
   endtask

   task automatic clear_log();
      log_en.delete();
      log_er.delete();
      log_d.delete();
      log_rdy.delete();
   endtask

   task automatic idle(int n);
      intf.in_valid_i = 1'b0;
      intf.in_last_i  = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // drives one payload; drop_after >= 0 withholds valid for one cycle before that byte
   task automatic send_frame(bq_t p, int drop_after);
      int i, guard;
      bit dropped, hs;
      i = 0;
      guard = 0;
      dropped = 1'b0;
      while (i < p.size() && guard < 5000) begin
         guard++;
         if (i == drop_after && !dropped) begin
            intf.in_valid_i = 1'b0;
            intf.in_last_i  = 1'b0;
            dropped = 1'b1;
            @(posedge clk);
            #1;
         end else begin
            intf.in_valid_i = 1'b1;
            intf.in_data_i  = p[i];
            intf.in_last_i  = (i == p.size() - 1);
            hs = intf.in_ready_o;
            @(posedge clk);
            #1;
            if (hs) i++;
         end
      end
      intf.in_valid_i = 1'b0;
      intf.in_last_i  = 1'b0;
      n_checks++;
      if (i != p.size()) begin
         n_fail++;
         $display("FAIL source_timeout: accepted %0d bytes, required %0d", i, p.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      intf.in_valid_i = 1'b1;
      intf.in_last_i  = 1'b0;
      intf.in_data_i  = 8'hA5;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (en !== 1'b0)   begin n_fail++; $display("FAIL reset_en: got %b want 0", en); end
      n_checks++; if (er !== 1'b0)   begin n_fail++; $display("FAIL reset_er: got %b want 0", er); end
      n_checks++; if (d !== 8'h00)   begin n_fail++; $display("FAIL reset_data: got %h want 00", d); end
      n_checks++; if (intf.in_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", intf.in_ready_o); end
      intf.in_valid_i = 1'b0;
      rst = 1'b0;
      idle(2);
   endtask

   task automatic test_known_vector();
      bq_t p, exp;
      int  df;
      for (int i = 0; i < 9; i++) p.push_back(8'(8'h31 + i));
`ifdef GMII_TX_PAD_EN
      exp = model_frame(p, -1);
`else
      for (int i = 0; i < 7; i++) exp.push_back(8'h55);
      exp.push_back(8'hD5);
      foreach (p[i]) exp.push_back(p[i]);
      exp.push_back(8'h26); exp.push_back(8'h39); exp.push_back(8'hF4); exp.push_back(8'hCB);
`endif
      clear_log();
      send_frame(p, -1);
      idle(100);
      find_runs();
      n_checks++;
      if (run_st.size() != 1) begin n_fail++; $display("FAIL known_runs: got %0d want 1", run_st.size()); end
      else begin
         n_checks++;
         if (run_ln[0] != (PAD_EN ? 72 : 21)) begin n_fail++; $display("FAIL known_en_len: got %0d want %0d", run_ln[0], PAD_EN ? 72 : 21); end
         df = first_diff(run_st[0], exp);
         n_checks++;
         if (df != -1) begin n_fail++; $display("FAIL known_bytes: byte %0d got %h want %h", df, log_d[run_st[0]+df], exp[df]); end
         n_checks++;
         if (er_count(run_st[0], run_ln[0]) != 0) begin n_fail++; $display("FAIL known_er: got %0d er cycles want 0", er_count(run_st[0], run_ln[0])); end
      end
   endtask

   task automatic test_pad();
      int  lens[4] = '{1, 59, 60, 61};
      bq_t p, exp;
      int  want_len, df;
      foreach (lens[t]) begin
         p = rand_payload(lens[t]);
         if (lens[t] == 1) p[0] = 8'hAB;
         exp = model_frame(p, -1);
         want_len = PL + 1 + ((PAD_EN && lens[t] < MINF) ? MINF : lens[t]) + 4;
         clear_log();
         send_frame(p, -1);
         idle(120);
         find_runs();
         n_checks++;
         if (run_st.size() != 1) begin n_fail++; $display("FAIL pad_runs len=%0d: got %0d want 1", lens[t], run_st.size()); end
         else begin
            n_checks++;
            if (run_ln[0] != want_len) begin n_fail++; $display("FAIL pad_en_len len=%0d: got %0d want %0d", lens[t], run_ln[0], want_len); end
            df = first_diff(run_st[0], exp);
            n_checks++;
            if (df != -1) begin n_fail++; $display("FAIL pad_bytes len=%0d: byte %0d got %h want %h", lens[t], df, log_d[run_st[0]+df], exp[df]); end
         end
      end
   endtask

   task automatic test_random_frames();
      bq_t frames[$];
      bq_t p, exp;
      int  total, df;
      total = 0;
      clear_log();
      for (int f = 0; f < 8; f++) begin
         p = rand_payload($urandom_range(1, 100));
         frames.push_back(p);
         total += p.size();
         send_frame(p, -1);
         idle($urandom_range(0, 15));
      end
      idle(150);
      find_runs();
      n_checks++;
      if (run_st.size() != 8) begin n_fail++; $display("FAIL rand_runs: got %0d want 8", run_st.size()); end
      else begin
         for (int f = 0; f < 8; f++) begin
            exp = model_frame(frames[f], -1);
            df = first_diff(run_st[f], exp);
            n_checks++;
            if (df != -1 || run_ln[f] != exp.size()) begin
               n_fail++;
               $display("FAIL rand_frame %0d: len %0d want %0d, first bad byte %0d", f, run_ln[f], exp.size(), df);
            end
            if (f > 0) begin
               n_checks++;
               if (run_st[f] - (run_st[f-1] + run_ln[f-1]) < IFG) begin
                  n_fail++;
                  $display("FAIL rand_gap %0d: got %0d want >= %0d", f, run_st[f] - (run_st[f-1] + run_ln[f-1]), IFG);
               end
            end
         end
      end
      n_checks++;
      if (rdy_count() != total) begin n_fail++; $display("FAIL rand_ready_cycles: got %0d want %0d", rdy_count(), total); end
   endtask

   task automatic test_back_to_back();
      bq_t a, b, ea, eb;
      int  gap;
      a = rand_payload(64);
      b = rand_payload(64);
      ea = model_frame(a, -1);
      eb = model_frame(b, -1);
      clear_log();
      send_frame(a, -1);
      send_frame(b, -1);
      idle(150);
      find_runs();
      n_checks++;
      if (run_st.size() != 2) begin n_fail++; $display("FAIL b2b_runs: got %0d want 2", run_st.size()); end
      else begin
         gap = run_st[1] - (run_st[0] + run_ln[0]);
         n_checks++;
         if (gap != IFG) begin n_fail++; $display("FAIL b2b_gap: got %0d want %0d", gap, IFG); end
         n_checks++;
         if (first_diff(run_st[0], ea) != -1 || run_ln[0] != ea.size()) begin n_fail++; $display("FAIL b2b_frame0: len %0d want %0d", run_ln[0], ea.size()); end
         n_checks++;
         if (first_diff(run_st[1], eb) != -1 || run_ln[1] != eb.size()) begin n_fail++; $display("FAIL b2b_frame1: len %0d want %0d", run_ln[1], eb.size()); end
      end
   endtask

   task automatic test_underrun();
      bq_t p, q, ep, eq;
      int  gap, ec;
      p = rand_payload(20);
      q = rand_payload(16);
      ep = model_frame(p, 10);
      eq = model_frame(q, -1);
      clear_log();
      send_frame(p, 10);
      send_frame(q, -1);
      idle(150);
      find_runs();
      n_checks++;
      if (run_st.size() != 2) begin n_fail++; $display("FAIL under_runs: got %0d want 2", run_st.size()); end
      else begin
         n_checks++;
         if (first_diff(run_st[0], ep) != -1 || run_ln[0] != ep.size()) begin n_fail++; $display("FAIL under_frame: len %0d want %0d", run_ln[0], ep.size()); end
         ec = er_count(run_st[0], run_ln[0]);
         n_checks++;
         if (ec != 1 || log_er[run_st[0] + run_ln[0] - 1] !== 1'b1) begin n_fail++; $display("FAIL under_er: got %0d er cycles, last er %b, want 1 on last byte", ec, log_er[run_st[0] + run_ln[0] - 1]); end
         gap = run_st[1] - (run_st[0] + run_ln[0]);
         n_checks++;
         if (gap != IFG) begin n_fail++; $display("FAIL under_gap: got %0d want %0d", gap, IFG); end
         n_checks++;
         if (first_diff(run_st[1], eq) != -1 || run_ln[1] != eq.size()) begin n_fail++; $display("FAIL under_next_frame: len %0d want %0d", run_ln[1], eq.size()); end
         n_checks++;
         if (er_count(run_st[1], run_ln[1]) != 0) begin n_fail++; $display("FAIL under_next_er: got %0d want 0", er_count(run_st[1], run_ln[1])); end
      end
      n_checks++;
      if (rdy_count() != 37) begin n_fail++; $display("FAIL under_ready_cycles: got %0d want 37", rdy_count()); end
   endtask

   task automatic test_reset_mid_fcs();
      bq_t p, r, ep, er_exp;
      int  k, guard, df;
      p = rand_payload(20);
      ep = model_frame(p, -1);
      k = 0;
      guard = 0;
      fork
         send_frame(p, -1);
         begin
            while (k < ep.size() - 2 && guard < 500) begin
               @(negedge clk);
               guard++;
               if (en === 1'b1) k++;
            end
         end
      join
      n_checks++;
      if (k != ep.size() - 2) begin n_fail++; $display("FAIL rst_reach_fcs: got %0d en cycles want %0d", k, ep.size() - 2); end
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_checks++; if (en !== 1'b0) begin n_fail++; $display("FAIL rst_mid_en: got %b want 0", en); end
      n_checks++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data: got %h want 00", d); end
      n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL rst_mid_er: got %b want 0", er); end
      rst = 1'b0;
      r = rand_payload(8);
      er_exp = model_frame(r, -1);
      clear_log();
      send_frame(r, -1);
      idle(120);
      find_runs();
      n_checks++;
      if (run_st.size() != 1) begin n_fail++; $display("FAIL rst_next_runs: got %0d want 1", run_st.size()); end
      else begin
         df = first_diff(run_st[0], er_exp);
         n_checks++;
         if (df != -1 || run_ln[0] != er_exp.size()) begin n_fail++; $display("FAIL rst_next_frame: len %0d want %0d, first bad byte %0d", run_ln[0], er_exp.size(), df); end
      end
   endtask

   // valid stays high across FCS, IFG and PRE of the second frame; ready must only cover SFD..last payload
   task automatic test_stall();
      bq_t a, b;
      int  lens[2];
      int  bad, r, o;
      a = rand_payload(1);
      b = rand_payload(5);
      lens[0] = 1;
      lens[1] = 5;
      clear_log();
      send_frame(a, -1);
      send_frame(b, -1);
      idle(120);
      find_runs();
      n_checks++;
      if (run_st.size() != 2) begin n_fail++; $display("FAIL stall_runs: got %0d want 2", run_st.size()); end
      else begin
         bad = 0;
         foreach (log_rdy[j]) begin
            if (log_rdy[j] === 1'b1) begin
               r = (j >= run_st[1]) ? 1 : 0;
               o = j - run_st[r];
               if (o < PL || o > PL + lens[r] - 1) bad++;
            end
         end
         n_checks++;
         if (bad != 0) begin n_fail++; $display("FAIL stall_ready_window: got %0d stray ready cycles want 0", bad); end
         n_checks++;
         if (rdy_count() != 6) begin n_fail++; $display("FAIL stall_ready_cycles: got %0d want 6", rdy_count()); end
      end
   endtask

   initial begin
      intf.in_valid_i = 1'b0;
      intf.in_last_i  = 1'b0;
      intf.in_data_i  = 8'h00;
      test_reset();
      test_known_vector();
      test_pad();
      test_random_frames();
      test_back_to_back();
      test_underrun();
      test_reset_mid_fcs();
      test_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gmii_tx_framer.md
# gmii_tx_framer

Transmit-side GMII framer: the egress counterpart of the receive-side FCS check/strip stage. Accepts a frame as a byte stream without preamble or FCS, and emits a complete GMII frame: 7×0x55 preamble, 0xD5 SFD, payload, optional zero padding, and a 4-byte CRC-32 FCS. It also enforces the minimum inter-frame gap and sits directly in front of the GMII TX pins.

## Interface
- `PREAMBLE_LEN`, default 7: number of 0x55 bytes before the SFD.
- `MIN_IFG`, default 12: minimum number of `gmii_en_o`-low cycles between frames.
- `MIN_FRAME`, default 60: minimum payload-plus-pad bytes, excluding FCS (used only with `GMII_TX_PAD_EN`).
- `clk` in 1: GMII TX clock, 125 MHz.
- `rst` in 1: synchronous reset, active-high.
- `in_valid_i` in 1: payload byte valid.
- `in_last_i` in 1: current byte is the last payload byte.
- `in_data_i` in 8: payload byte.
- `in_ready_o` out 1: framer accepts a byte this cycle.
- `gmii_en_o` out 1: GMII TX_EN.
- `gmii_er_o` out 1: GMII TX_ER.
- `gmii_data_o` out 8: GMII TXD.

## Operation
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG.
- IDLE:
  - `in_valid_i`=1 → PRE; the frame starts.
  - The first byte is not consumed in IDLE.
- PRE: emits 0x55 for `PREAMBLE_LEN` cycles, then goes to SFD.
- SFD: emits 0xD5 for 1 cycle, then goes to DATA.
- DATA:
  - `in_ready_o`=1 (decoded from state only).
  - Each handshake (valid & ready) emits the byte and updates the CRC.
  - On the last byte: → PAD if padding is enabled and the byte count is < `MIN_FRAME`, else → FCS.
- Underrun (DATA with `in_valid_i`=0):
  - Emits one byte 0x00 with `gmii_er_o`=1 and `gmii_en_o`=1.
  - Then goes to IFG. The frame is aborted and no FCS is sent.
  - Remaining source bytes up to and including `in_last_i` are discarded: `in_ready_o`=1 in IFG only while draining.
- PAD: emits 0x00, CRC included, until the count reaches `MIN_FRAME`, then goes to FCS.
- FCS: emits 4 bytes, `~crc[7:0]` first, then `[15:8]`, `[23:16]`, `[31:24]`; then goes to IFG.
- IFG:
  - `gmii_en_o`=0 for exactly `MIN_IFG` cycles, then → IDLE.
  - If `in_valid_i` is already high, PRE follows with no extra cycle.
- CRC-32:
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Updated per byte, LSB first; reset to init in SFD.
- Byte counter: 11 bits, saturates at 2047; cleared in SFD.
- Frames longer than 2047 bytes are transmitted intact; only the pad decision uses the counter.
- `in_last_i` is ignored unless handshaked.

## Timing
- All outputs are registered.
- Reset values: `gmii_en_o`=0, `gmii_er_o`=0, `gmii_data_o`=0x00, `in_ready_o`=0; state = IDLE; CRC = 0xFFFFFFFF.
- `in_valid_i` rises in IDLE at cycle t → first 0x55 on the pins at t+1 → SFD at t+1+`PREAMBLE_LEN`.
- A DATA byte handshaked at cycle t appears on `gmii_data_o` at t+1.
- The first payload byte directly follows the SFD on the pins, with no bubble.
- `gmii_en_o` is continuous from the first 0x55 through the last FCS byte.
- After the last FCS byte, `gmii_en_o`=0 for exactly `MIN_IFG` cycles when the next frame is already pending.
- `rst` mid-frame: next cycle all outputs are at reset values. The truncated frame is not completed and no IFG is inserted.
- `gmii_er_o` is high only for the single underrun byte.

## Configuration
- `GMII_TX_PAD_EN` defined:
  - Payloads shorter than `MIN_FRAME` are zero-padded before the FCS.
  - The FCS covers the pad bytes.
- `GMII_TX_PAD_EN` undefined:
  - The PAD state is not compiled.
  - DATA goes straight to FCS after the last byte, whatever the length.

## Test plan
- Pad off; payload "123456789" (0x31..0x39) → on the pins: 7×0x55, 0xD5, 0x31..0x39, then 0x26, 0x39, 0xF4, 0xCB. `gmii_en_o` high for exactly 21 cycles.
- Pad on; 1-byte payload 0xAB → after the SFD: 0xAB followed by 59×0x00, then the FCS of those 60 bytes (checked against the bench model). `gmii_en_o` high for 72 cycles.
- Two 64-byte frames back-to-back, `in_valid_i` held high → `gmii_en_o` low for exactly 12 cycles between the last FCS byte and the next 0x55.
- Underrun: `in_valid_i` dropped for 1 cycle after 10 payload bytes → 0x00 with `gmii_er_o`=1 at byte 11, no FCS, then a 12-cycle gap. Remaining bytes through `in_last_i` are drained.
- `rst` pulsed in the middle of the FCS bytes → next cycle `gmii_en_o`=0 and `gmii_data_o`=0x00. A subsequent frame starts cleanly with its preamble and a correct FCS.
- Stall check: `in_ready_o` is never high outside DATA and the underrun drain, including during PRE, SFD, PAD, FCS and the IFG without drain.
